// File: rtl/stereo_pkg.sv
// Shared types and window sizing for the stereo block-matching datapath.
package stereo_pkg;

    localparam int WIN_W = 3;
    localparam int WIN_H = 2;
    // Accumulator wide enough for WIN_W*WIN_H worst-case squared differences
    localparam int ACC_W = $clog2(255 * 255 * WIN_W * WIN_H) + 1;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/ssd_window_feeder_valid_delay_line.sv
// Fixed-depth 1-bit shift register that aligns an address-valid tag with BRAM read data.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic tag,
    output logic tag_dly
);

    logic [DEPTH-1:0] tag_sr;

    // Advance the tag one stage per cycle; reset flushes every stage
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tag_sr <= '0;
        end else begin
            tag_sr[0] <= tag;
            for (int s = 1; s < DEPTH; s++) begin
                tag_sr[s] <= tag_sr[s-1];
            end
        end
    end

    assign tag_dly = tag_sr[DEPTH-1];

endmodule

// File: rtl/ssd_window_feeder.sv
// Sequences one stereo SSD window: issues clamped left/right BRAM addresses,
// realigns returning pixels into valid pairs for the MAC, and signals completion.
module ssd_window_feeder
    import stereo_pkg::*;
#(
    parameter int WIDTH    = 320,
    parameter int HEIGHT   = 240,
    parameter int MAX_DISP = 64,
    parameter int READ_LAT = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    input  logic [$clog2(WIDTH)-1:0]          x_in,
    input  logic [$clog2(HEIGHT)-1:0]         y_in,
    input  logic [$clog2(MAX_DISP+1)-1:0]     disp_in,
    output logic                              busy_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   left_addr_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   right_addr_out,
    input  pixel_t                            left_data_in,
    input  pixel_t                            right_data_in,
    output pixel_t                            left_pixel_out,
    output pixel_t                            right_pixel_out,
    output logic                              pair_valid_out,
    output logic                              mac_clear_out,
    output logic                              window_done_out
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int DW = $clog2(MAX_DISP + 1);
    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int CW = XW + 2;            // column plus carry plus sign
    localparam int RW = YW + 1;            // row plus carry
    localparam int IW = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int JW = (WIN_H > 1) ? $clog2(WIN_H) : 1;
    localparam int NW = $clog2(READ_LAT + 2);

    feeder_state_t state, state_nxt;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [DW-1:0] disp_q;
    logic [IW-1:0] i_cnt;
    logic [JW-1:0] j_cnt;
    logic [NW-1:0] drain_cnt;
    logic          issue_last;
    logic          drain_last;
    logic          vld_p0;
    logic          vld_p1;

    logic signed [CW-1:0] lcol_s;
    logic signed [CW-1:0] rcol_s;
    logic [RW-1:0]        row_s;
    logic [AW-1:0]        row_base;
    logic [AW-1:0]        left_addr_c;
    logic [AW-1:0]        right_addr_c;

    function automatic logic [DW-1:0] sat_disp(input logic [DW-1:0] d);
        if (d > DW'(MAX_DISP)) return DW'(MAX_DISP);
        return d;
    endfunction

    function automatic logic [XW-1:0] clamp_col(input logic signed [CW-1:0] c);
        if (c[CW-1]) return '0;
        if (c > $signed(CW'(WIDTH - 1))) return XW'(WIDTH - 1);
        return c[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clamp_row(input logic [RW-1:0] r);
        if (r > RW'(HEIGHT - 1)) return YW'(HEIGHT - 1);
        return r[YW-1:0];
    endfunction

    assign issue_last = (i_cnt == IW'(WIN_W - 1)) && (j_cnt == JW'(WIN_H - 1));
    assign drain_last = (drain_cnt == NW'(READ_LAT));

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and control outputs
    always_comb begin
        state_nxt       = state;
        busy_out        = 1'b0;
        mac_clear_out   = 1'b0;
        window_done_out = 1'b0;
        vld_p0          = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy_out      = 1'b1;
                vld_p0        = 1'b1;
                mac_clear_out = (i_cnt == '0) && (j_cnt == '0);
                if (issue_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_out = 1'b1;
                if (drain_last) state_nxt = DONE;
            end
            DONE: begin
                busy_out        = 1'b1;
                window_done_out = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and row-major window / drain counters
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_q       <= '0;
            y_q       <= '0;
            disp_q    <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && start_in) begin
                x_q       <= x_in;
                y_q       <= y_in;
                disp_q    <= sat_disp(disp_in);
                i_cnt     <= '0;
                j_cnt     <= '0;
                drain_cnt <= '0;
            end
            if (state == ISSUE) begin
                if (i_cnt == IW'(WIN_W - 1)) begin
                    i_cnt <= '0;
                    j_cnt <= j_cnt + 1'b1;
                end else begin
                    i_cnt <= i_cnt + 1'b1;
                end
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
        end
    end

    // Clamped address generation; sign bit keeps x+i-disp from wrapping
    always_comb begin
        lcol_s       = CW'(x_q) + CW'(i_cnt);
        rcol_s       = lcol_s - CW'(disp_q);
        row_s        = RW'(y_q) + RW'(j_cnt);
        row_base     = AW'(clamp_row(row_s)) * AW'(WIDTH);
        left_addr_c  = row_base + AW'(clamp_col(lcol_s));
        right_addr_c = row_base + AW'(clamp_col(rcol_s));
    end

    assign left_addr_out  = vld_p0 ? left_addr_c  : '0;
    assign right_addr_out = vld_p0 ? right_addr_c : '0;

    // ---- stage boundary: address issue -> BRAM data return ----
    valid_delay_line #(
        .DEPTH (READ_LAT)
    ) u_tag_dly (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tag     (vld_p0),
        .tag_dly (vld_p1)
    );

    // ---- stage boundary: BRAM data -> registered MAC pair ----
    // Capture returning pixels as a pair for the MAC
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pair_valid_out  <= 1'b0;
            left_pixel_out  <= '0;
            right_pixel_out <= '0;
        end else begin
            pair_valid_out <= vld_p1;
            if (vld_p1) begin
                left_pixel_out  <= left_data_in;
                right_pixel_out <= right_data_in;
            end
        end
    end

endmodule
